// File: rtl/gpr_pkg.sv
// Shared register-file definitions: architectural sizes and the index/word
// types used by the register file, the ALU and control decode.
package gpr_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int unsigned REG_ZERO = 0;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_word_t;

endpackage : gpr_pkg

// File: rtl/gpr_read_port.sv
// One combinational operand read port: hardwired zero, then pending-stage
// bypass, then the committed array.
module gpr_read_port
   import gpr_pkg::*;
#(
   parameter int DATA_W   = gpr_pkg::DATA_W,
   parameter int ADDR_W   = gpr_pkg::ADDR_W,
   parameter int NUM_REGS = gpr_pkg::NUM_REGS
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              pend_valid,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic [DATA_W-1:0] pend_data,
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   output logic [DATA_W-1:0] value
);

   logic w_hit;

   assign w_hit = pend_valid && (pend_addr == addr);

   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      value = regs[addr];
      if (w_hit) begin
         value = pend_data;
      end
      if (addr == ADDR_W'(REG_ZERO)) begin
         value = '0;
      end
   end

endmodule : gpr_read_port

// File: rtl/gpr_file_wb.sv
// General-purpose register file with a one-entry write-back pending stage,
// bypassed operand reads and a committed-write counter.
module gpr_file_wb
   import gpr_pkg::*;
#(
   parameter int DATA_W   = gpr_pkg::DATA_W,
   parameter int ADDR_W   = gpr_pkg::ADDR_W,
   parameter int NUM_REGS = gpr_pkg::NUM_REGS  // must equal 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_value,
   output logic [DATA_W-1:0] rt_value,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              pend_valid,
   output logic [31:0]       wr_count
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_pend_valid;
   logic [ADDR_W-1:0] r_pend_addr;
   logic [DATA_W-1:0] r_pend_data;
   logic [31:0]       r_wr_count;
   logic              w_wb_accept;

   // Writes to register zero are dropped before they reach the pending stage.
   assign w_wb_accept = wb_en && (wb_addr != ADDR_W'(REG_ZERO));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; this is what lets commit and load share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_data  <= '0;
      end else begin
         r_pend_valid <= w_wb_accept;
         if (w_wb_accept) begin
            r_pend_addr <= wb_addr;
            r_pend_data <= wb_data;
         end
      end
   end

   // NOTE: the array is reset explicitly because reads must return zero for
   // every index during and after reset; this keeps it in flops, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_wr_count <= '0;
      end else if (r_pend_valid) begin
         r_regs[r_pend_addr] <= r_pend_data;
         r_wr_count          <= r_wr_count + 32'd1;
      end
   end

   gpr_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rs_port (
      .addr       (rs_addr),
      .pend_valid (r_pend_valid),
      .pend_addr  (r_pend_addr),
      .pend_data  (r_pend_data),
      .regs       (r_regs),
      .value      (rs_value)
   );

   gpr_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rt_port (
      .addr       (rt_addr),
      .pend_valid (r_pend_valid),
      .pend_addr  (r_pend_addr),
      .pend_data  (r_pend_data),
      .regs       (r_regs),
      .value      (rt_value)
   );

   assign pend_valid = r_pend_valid;
   assign wr_count   = r_wr_count;

endmodule : gpr_file_wb
